// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program sequencer for the 4-bit CPU.
// The sequencer owns the PC and drives the address of a combinational instruction ROM.
// It latches each instruction and resolves NOP/JMP/JZ/HLT by itself.
// Every other opcode goes to the datapath over a valid/ready handshake.
// Optional build macro SINGLE_STEP_EN adds a 'step' input and a STEP_WAIT
// state, so that one instruction runs per step pulse.
module fetch_sequencer #(
    parameter logic [3:0] HLT_OP = 4'b1111,
    parameter logic [3:0] JMP_OP = 4'b1000,
    parameter logic [3:0] JZ_OP  = 4'b1001,
    parameter logic [3:0] NOP_OP = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_instr,
    input  logic       zero_flag,
    output logic       exec_valid,
    output logic [3:0] exec_op,
    output logic [3:0] exec_operand,
    input  logic       exec_ready,
    output logic       busy,
    output logic       halted
`ifdef SINGLE_STEP_EN
    ,
    input  logic       step
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXEC      = 3'd3,
        HALT      = 3'd4
`ifdef SINGLE_STEP_EN
        ,
        STEP_WAIT = 3'd5
`endif
    } state_t;

    // After each instruction completes, the sequencer moves to this state.
    // In single-step builds it parks in STEP_WAIT. Otherwise it goes straight back to FETCH.
`ifdef SINGLE_STEP_EN
    localparam state_t RESUME = STEP_WAIT;
`else
    localparam state_t RESUME = FETCH;
`endif

    state_t     state;
    logic [3:0] pc;
    logic [7:0] ir;

    // The ROM address is the PC register itself. The datapath fields mirror the IR.
    assign imem_addr    = pc;
    assign exec_op      = ir[7:4];
    assign exec_operand = ir[3:0];

    // Status flags are decoded only from the state flop, so they never see a combinational input path.
    assign halted = (state == HALT);
    assign busy   = (state != IDLE) && (state != HALT);

    // Sequencer FSM: PC, IR, state and the exec_valid handshake flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= 4'h0;
            ir         <= 8'h00;
            exec_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) assignments only.
            // Every register in this block then sees the pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    ir    <= imem_instr;
                    state <= DECODE;
                end

                DECODE: begin
                    if (ir[7:4] == HLT_OP) begin
                        state <= HALT;
                    end else if (ir[7:4] == JMP_OP) begin
                        pc    <= ir[3:0];
                        state <= RESUME;
                    end else if (ir[7:4] == JZ_OP) begin
                        pc    <= zero_flag ? ir[3:0] : pc + 4'd1;
                        state <= RESUME;
                    end else if (ir[7:4] == NOP_OP) begin
                        pc    <= pc + 4'd1;
                        state <= RESUME;
                    end else begin
                        exec_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    // The stall has no bound: this state holds until the datapath takes the instruction.
                    if (exec_valid && exec_ready) begin
                        exec_valid <= 1'b0;
                        pc         <= pc + 4'd1;
                        state      <= RESUME;
                    end
                end

                HALT: begin
                    state <= HALT;
                end

`ifdef SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step) begin
                        state <= FETCH;
                    end
                end
`endif

                default: begin
                    exec_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer.
// The ROM is modelled in the bench. A queue holds the datapath instructions expected on the handshake.
// A negedge monitor pops that queue on every accepted exec transfer.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] imem_addr;
    logic [7:0] imem_instr;
    logic       zero_flag;
    logic       exec_valid;
    logic [3:0] exec_op;
    logic [3:0] exec_operand;
    logic       exec_ready;
    logic       busy;
    logic       halted;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif

    logic [7:0] rom [16];
    logic [7:0] sb_q [$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr];

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .zero_flag    (zero_flag),
        .exec_valid   (exec_valid),
        .exec_op      (exec_op),
        .exec_operand (exec_operand),
        .exec_ready   (exec_ready),
        .busy         (busy),
        .halted       (halted)
`ifdef SINGLE_STEP_EN
        ,
        .step         (step)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock, then settle 1ns past the edge. All driving and sampling in the main thread happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse run for one cycle, then count cycles until HALT. The count starts from FETCH entry.
    task automatic run_prog(input int bound, output int n, output int pulses);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("busy_after_run", busy, 1);
        n      = 0;
        pulses = 0;
        while (!halted && n < bound) begin
            tick();
            n++;
            if (exec_valid) pulses++;
        end
    endtask

    // Scoreboard monitor: every accepted datapath transfer must match the next queued instruction.
    always @(negedge clk) begin
        if (rst_n && exec_valid && exec_ready) begin
            if (sb_q.size() == 0) begin
                check("exec_unexpected", 1, 0);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("sb_exec_op", exec_op, e[7:4]);
                check("sb_exec_operand", exec_operand, e[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;

        rst_n      = 1'b0;
        run        = 1'b0;
        zero_flag  = 1'b0;
        exec_ready = 1'b0;
`ifdef SINGLE_STEP_EN
        step       = 1'b0;
`endif
        clear_rom();
        #1;
        check("rst_exec_valid", exec_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", imem_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_run_busy", busy, 0);

        // Datapath op followed by HLT; exec_ready is held high throughout.
        clear_rom();
        rom[0] = 8'h23;
        rom[1] = 8'hF0;
        exec_ready = 1'b1;
        sb_q.push_back(8'h23);
        run_prog(20, n, pulses);
        check("t1_halted", halted, 1);
        check("t1_cycles", n, 5);
        check("t1_pulses", pulses, 1);
        check("t1_addr", imem_addr, 1);
        check("t1_busy", busy, 0);

        // JMP 5 to an HLT. No handshake is expected.
        do_reset();
        clear_rom();
        rom[0] = 8'h85;
        rom[5] = 8'hF0;
        run_prog(20, n, pulses);
        check("jmp_halted", halted, 1);
        check("jmp_cycles", n, 4);
        check("jmp_pulses", pulses, 0);
        check("jmp_addr", imem_addr, 5);

        // JZ is taken when zero_flag is high.
        do_reset();
        clear_rom();
        rom[0] = 8'h9A;
        zero_flag = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("jz_taken_addr", imem_addr, 4'hA);

        // JZ falls through when zero_flag is low.
        do_reset();
        zero_flag = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("jz_not_taken_addr", imem_addr, 4'h1);

        // Stall: exec_ready is held low for 6 cycles in EXEC.
        do_reset();
        clear_rom();
        rom[0] = 8'h31;
        rom[1] = 8'hF0;
        exec_ready = 1'b0;
        sb_q.push_back(8'h31);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            check("stall_valid", exec_valid, 1);
            check("stall_op", exec_op, 3);
            check("stall_operand", exec_operand, 1);
            check("stall_addr", imem_addr, 0);
            tick();
        end
        exec_ready = 1'b1;
        tick();
        check("stall_release_valid", exec_valid, 0);
        check("stall_release_addr", imem_addr, 1);

        // PC wraps: JMP 15 lands on a NOP, and pc+1 then wraps to 0.
        do_reset();
        clear_rom();
        rom[0]  = 8'h8F;
        rom[15] = 8'h00;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("wrap_at_f", imem_addr, 4'hF);
        tick();
        tick();
        check("wrap_to_0", imem_addr, 4'h0);
        check("wrap_busy", busy, 1);

        // Reset asserted mid-EXEC takes effect with no clock edge.
        do_reset();
        clear_rom();
        rom[0] = 8'h31;
        exec_ready = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("midexec_valid_before", exec_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midexec_rst_valid", exec_valid, 0);
        check("midexec_rst_addr", imem_addr, 0);
        check("midexec_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        exec_ready = 1'b1;
        tick();
        tick();
        check("post_rst_idle_busy", busy, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("post_rst_restart_busy", busy, 1);

`ifdef SINGLE_STEP_EN
        // Single step: after the NOP the sequencer parks until step is pulsed.
        do_reset();
        clear_rom();
        rom[0] = 8'h00;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("step_wait_addr", imem_addr, 1);
        check("step_wait_busy", busy, 1);
        check("step_wait_halted", halted, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("step_halted", halted, 1);
`endif

        do_reset();
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program sequencer for the 4-bit CPU. It owns the program counter and drives the 4-bit address of the combinational 8-bit-wide instruction ROM. It latches the returned instruction and resolves control-flow opcodes (NOP/JMP/JZ/HLT) locally. All other opcodes go to the ALU/register datapath over a valid/ready handshake.

Parameters:
HLT_OP, 4'b1111, opcode that halts the sequencer
JMP_OP, 4'b1000, unconditional jump to operand address
JZ_OP, 4'b1001, jump to operand address if zero_flag=1
NOP_OP, 4'b0000, no operation; PC increments

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  start request; sampled only in IDLE
imem_addr  output  4  ROM address; equals the PC register at all times
imem_instr  input  8  ROM data: [7:4] opcode, [3:0] operand; combinational from imem_addr
zero_flag  input  1  datapath zero flag; sampled in DECODE for JZ
exec_valid  output  1  datapath instruction valid
exec_op  output  4  opcode of the latched IR
exec_operand  output  4  operand of the latched IR
exec_ready  input  1  datapath accepts the instruction
busy  output  1  high in any state other than IDLE and HALT
halted  output  1  high in HALT

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync deassert use) forces:
  - state=IDLE, pc=0, ir=8'h00
  - exec_valid=0, busy=0, halted=0
- Effect is immediate, in any state, including mid-EXEC with exec_valid=1.
- States: IDLE, FETCH, DECODE, EXEC, HALT (binary encoded).
- IDLE:
  - run=1 -> FETCH.
  - run ignored in all other states; deasserting run mid-program has no effect.
- FETCH: ir<=imem_instr at the clock edge -> DECODE. Exactly one cycle.
- DECODE, on ir[7:4]:
  - HLT_OP -> HALT; pc unchanged.
  - JMP_OP -> pc<=ir[3:0]; -> FETCH.
  - JZ_OP -> pc<=zero_flag ? ir[3:0] : pc+1; -> FETCH.
  - NOP_OP -> pc<=pc+1; -> FETCH.
  - Any other opcode -> exec_valid<=1; -> EXEC.
- EXEC:
  - exec_valid held at 1; exec_op and exec_operand are stable.
  - On a cycle with exec_valid=1 and exec_ready=1: exec_valid<=0, pc<=pc+1, -> FETCH.
  - Stall is unbounded while exec_ready=0.
- HALT: halted=1, busy=0. Left only by reset.
- PC arithmetic is 4-bit modulo: pc+1 at 4'hF wraps to 4'h0. A JMP target may equal the current pc (self-loop is legal).
- Latency:
  - Control-flow instruction: 2 cycles (FETCH, DECODE).
  - Datapath instruction: 3 cycles minimum (FETCH, DECODE, EXEC with ready=1).
- exec_op and exec_operand mirror ir continuously. Consumers must qualify them with exec_valid.
- exec_ready asserted outside EXEC is ignored.

Optional Feature:
SINGLE_STEP_EN:
- Defined:
  - Adds input port step (1 bit).
  - Adds state STEP_WAIT, entered wherever FETCH would otherwise be entered, except the first FETCH after IDLE.
  - STEP_WAIT -> FETCH on a cycle with step=1. Exactly one instruction executes per step pulse.
  - busy=1 in STEP_WAIT.
- Undefined: port step is absent and sequencing is continuous, as above.

Test Plan:
- Reset then run=1, ROM[0]=8'h23, ROM[1]=8'hF0, exec_ready=1:
  - exec_valid high for 1 cycle with exec_op=2, exec_operand=3.
  - Then halted=1, imem_addr=1.
  - Total 5 cycles from run.
- ROM[0]=8'h85 (JMP 5), ROM[5]=8'hF0: imem_addr goes 0 -> 5, no exec_valid pulse, halted=1 after 4 cycles.
- JZ:
  - ROM[0]=8'h9A with zero_flag=1 -> next imem_addr=4'hA.
  - Repeat with zero_flag=0 -> next imem_addr=1.
- Stall: ROM[0]=8'h31, exec_ready held 0 for 6 cycles.
  - exec_valid stays 1 with exec_op=3 and exec_operand=1 stable; pc stays 0.
  - ready=1 -> pc=1 the next cycle.
- Wrap: ROM[15]=8'h00 (NOP), reached via JMP 15 -> imem_addr wraps to 0.
- Reset mid-EXEC: drop rst_n while exec_valid=1.
  - exec_valid=0, imem_addr=0, busy=0 immediately, without a clock edge.
  - After release, run is required to restart.
